// File: rtl/fft_pair_issuer_pkg.sv
// Shared constants and types for the butterfly operand source and its PE.
// Packed complex samples: real part in the upper half, imaginary in the lower half.
package fft_pair_issuer_pkg;

  localparam int FFT_POINTS = 16;
  localparam int FFT_DW     = 32;
  localparam int FFT_HALF   = FFT_POINTS / 2;
  localparam int FFT_PW     = $clog2(FFT_HALF);

  localparam int RE_HI = FFT_DW - 1;
  localparam int RE_LO = FFT_DW / 2;
  localparam int IM_HI = FFT_DW / 2 - 1;
  localparam int IM_LO = 0;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  function automatic logic [FFT_DW-1:0] pack_cplx(input logic [FFT_DW/2-1:0] re,
                                                  input logic [FFT_DW/2-1:0] im);
    logic [FFT_DW-1:0] s;
    s[RE_HI:RE_LO] = re;
    s[IM_HI:IM_LO] = im;
    return s;
  endfunction

endpackage

// File: rtl/fft_frame_buf.sv
// One-frame sample store: single write port, two combinational read ports
// returning the butterfly partners x[k] and x[k+POINTS/2].
module fft_frame_buf #(
  parameter int POINTS = 16,
  parameter int DW     = 32
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [$clog2(POINTS)-1:0]     waddr_i,
  input  logic [DW-1:0]                 wdata_i,
  input  logic [$clog2(POINTS/2)-1:0]   raddr_i,
  output logic [DW-1:0]                 lo_o,
  output logic [DW-1:0]                 hi_o
);

  logic [DW-1:0] mem_q [POINTS];

  // Contents are deliberately not reset; a frame is always fully rewritten before issue.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign lo_o = mem_q[{1'b0, raddr_i}];
  assign hi_o = mem_q[{1'b1, raddr_i}];

endmodule

// File: rtl/fft_pair_issuer.sv
// Collects a POINTS-sample frame, issues POINTS/2 butterfly operand pairs back to back,
// then counts PE result pulses to close the frame (timeout and stray pulses set sticky err).
module fft_pair_issuer
  import fft_pair_issuer_pkg::*;
#(
  parameter int POINTS  = FFT_POINTS,
  parameter int DW      = FFT_DW,
  parameter int TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DW-1:0]                 in_data,
  output logic                          in_ready,
  output logic [DW-1:0]                 pe_a,
  output logic [DW-1:0]                 pe_b,
  output logic [$clog2(POINTS/2)-1:0]   pe_power,
  output logic                          pe_ab_valid,
  input  logic                          pe_result_valid,
  output logic                          frame_done,
  output logic                          busy,
  output logic                          err
);

  localparam int HALF = POINTS / 2;
  localparam int AW   = $clog2(POINTS);
  localparam int PW   = $clog2(HALF);
  localparam int CW   = $clog2(HALF + 1) + 1;
  localparam int TW   = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   k_q, k_d;
  logic [CW-1:0]   rcnt_q, rcnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            in_ready_q, in_ready_d;
  logic            pe_vld_q, pe_vld_d;
  logic [DW-1:0]   pe_a_q, pe_a_d;
  logic [DW-1:0]   pe_b_q, pe_b_d;
  logic [PW-1:0]   pe_power_q, pe_power_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            wr_en;
  logic [PW-1:0]   rd_idx;
  logic [DW-1:0]   rd_lo, rd_hi;
  logic [CW-1:0]   rcnt_inc;

  assign wr_en    = (state_q == LOAD) && in_valid && in_ready_q;
  // Read one pair ahead so the registered operands line up with issue cycle k.
  assign rd_idx   = (state_q == ISSUE) ? k_q + PW'(1) : '0;
  assign rcnt_inc = rcnt_q + CW'(pe_result_valid);

  fft_frame_buf #(
    .POINTS (POINTS),
    .DW     (DW)
  ) u_buf (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wptr_q),
    .wdata_i (in_data),
    .raddr_i (rd_idx),
    .lo_o    (rd_lo),
    .hi_o    (rd_hi)
  );

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    k_d        = k_q;
    rcnt_d     = rcnt_q;
    timer_d    = timer_q;
    pe_vld_d   = 1'b0;
    pe_a_d     = pe_a_q;
    pe_b_d     = pe_b_q;
    pe_power_d = '0;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      LOAD: begin
        if (pe_result_valid) err_d = 1'b1;
        if (wr_en) begin
          wptr_d = wptr_q + AW'(1);
          if (wptr_q == AW'(POINTS - 1)) begin
            state_d  = ISSUE;
            k_d      = '0;
            pe_vld_d = 1'b1;
            pe_a_d   = rd_lo;
            pe_b_d   = rd_hi;
          end
        end
      end
      ISSUE: begin
        rcnt_d = rcnt_inc;
        if (k_q == PW'(HALF - 1)) begin
          state_d = WAIT;
          k_d     = '0;
        end else begin
          k_d        = k_q + PW'(1);
          pe_vld_d   = 1'b1;
          pe_a_d     = rd_lo;
          pe_b_d     = rd_hi;
          pe_power_d = k_q + PW'(1);
        end
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        rcnt_d  = rcnt_inc;
        if (rcnt_inc >= CW'(HALF)) begin
          done_d  = 1'b1;
          state_d = LOAD;
          rcnt_d  = '0;
          timer_d = '0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = LOAD;
          rcnt_d  = '0;
          timer_d = '0;
        end
      end
      default: state_d = LOAD;
    endcase

    in_ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= LOAD;
      wptr_q     <= '0;
      k_q        <= '0;
      rcnt_q     <= '0;
      timer_q    <= '0;
      in_ready_q <= 1'b0;
      pe_vld_q   <= 1'b0;
      pe_a_q     <= '0;
      pe_b_q     <= '0;
      pe_power_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      k_q        <= k_d;
      rcnt_q     <= rcnt_d;
      timer_q    <= timer_d;
      in_ready_q <= in_ready_d;
      pe_vld_q   <= pe_vld_d;
      pe_a_q     <= pe_a_d;
      pe_b_q     <= pe_b_d;
      pe_power_q <= pe_power_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign pe_a        = pe_a_q;
  assign pe_b        = pe_b_q;
  assign pe_power    = pe_power_q;
  assign pe_ab_valid = pe_vld_q;
  assign frame_done  = done_q;
  assign busy        = (state_q != LOAD);
  assign err         = err_q;

endmodule
